// File: rtl/bounce_counter_hold_if.sv
// Purpose : control/status bundle for bounce_counter_hold.
// Ports   : master drives the configuration and strobes and reads the counter status.
//           slave is the counter side.
interface bounce_counter_hold_if #(
  parameter int WIDTH = 3,
  parameter int HCW   = 2
);
  logic             en;
  logic [1:0]       mode;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] hold_val;
  logic [HCW-1:0]   hold_cycles;
  logic             hold_up_en;
  logic             hold_dn_en;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt;
  logic             dir;
  logic             holding;
  logic             turn;

  modport master (
    output en, mode, lo, hi, hold_val, hold_cycles, hold_up_en, hold_dn_en, load, load_val,
    input  cnt, dir, holding, turn
  );

  modport slave (
    input  en, mode, lo, hi, hold_val, hold_cycles, hold_up_en, hold_dn_en, load, load_val,
    output cnt, dir, holding, turn
  );
endinterface

// File: rtl/bounce_counter_hold.sv
// Purpose : up/down bounce/wrap counter with programmable turn points and a dwell at hold_val.
// Latency : every sampled input change shows in cnt after one rising edge; outputs are registers.
// Backpressure: none; en==0 freezes all state, load overrides en.
// Ports   : clk, rst (sync, active-low), bus (slave side: config/strobes in, cnt/dir/holding/turn out).
module bounce_counter_hold #(
  parameter int WIDTH = 3,
  parameter int HCW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  bounce_counter_hold_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_DN   = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [HCW-1:0]   HOLD_ONE = HCW'(1);

  state_t           state_q, state_d;
  logic             ret_dir_q, ret_dir_d;
  logic [HCW-1:0]   hold_ctr_q, hold_ctr_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             turn_q, turn_d;

  // step_* describe the result of one UP/DOWN step before hold entry is decided
  logic             wrap_mode;
  logic             eff_up;
  logic [WIDTH-1:0] step_cnt;
  logic             step_up;
  logic             step_turn;
  logic             hold_en_dir;

  // state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_UP;
      ret_dir_q  <= 1'b1;
      hold_ctr_q <= '0;
      cnt_q      <= '0;
      turn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_dir_q  <= ret_dir_d;
      hold_ctr_q <= hold_ctr_d;
      cnt_q      <= cnt_d;
      turn_q     <= turn_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d     = state_q;
    ret_dir_d   = ret_dir_q;
    hold_ctr_d  = hold_ctr_q;
    cnt_d       = cnt_q;
    turn_d      = 1'b0;
    wrap_mode   = (bus.mode == 2'b01) || (bus.mode == 2'b10);
    eff_up      = 1'b1;
    step_cnt    = cnt_q;
    step_up     = 1'b1;
    step_turn   = 1'b0;
    hold_en_dir = 1'b0;

    if (bus.load) begin
      // a load never enters a hold, even when load_val == hold_val
      cnt_d      = bus.load_val;
      state_d    = (bus.mode == 2'b10) ? ST_DN : ST_UP;
      hold_ctr_d = '0;
    end else if (!bus.en) begin
      turn_d = 1'b0;
    end else if (bus.lo >= bus.hi) begin
      // empty range: park at lo, abort any hold
      cnt_d      = bus.lo;
      state_d    = ST_UP;
      hold_ctr_d = '0;
    end else if (state_q == ST_HOLD) begin
      hold_ctr_d = hold_ctr_q - HOLD_ONE;
      if (hold_ctr_q <= HOLD_ONE) begin
        state_d = ret_dir_q ? ST_UP : ST_DN;
      end
    end else begin
      // wrap modes force the stored direction before acting on it
      if (bus.mode == 2'b01) begin
        eff_up = 1'b1;
      end else if (bus.mode == 2'b10) begin
        eff_up = 1'b0;
      end else begin
        eff_up = (state_q == ST_UP);
      end

      if (eff_up) begin
        if (cnt_q >= bus.hi) begin
          step_cnt  = wrap_mode ? bus.lo : (cnt_q - CNT_ONE);
          step_up   = wrap_mode;
          step_turn = 1'b1;
        end else begin
          step_cnt = cnt_q + CNT_ONE;
          step_up  = 1'b1;
        end
      end else begin
        if (cnt_q <= bus.lo) begin
          step_cnt  = wrap_mode ? bus.hi : (cnt_q + CNT_ONE);
          step_up   = !wrap_mode;
          step_turn = 1'b1;
        end else begin
          step_cnt = cnt_q - CNT_ONE;
          step_up  = 1'b0;
        end
      end

      cnt_d  = step_cnt;
      turn_d = step_turn;

      // the hold enable is chosen by the direction in effect after the step
      hold_en_dir = step_up ? bus.hold_up_en : bus.hold_dn_en;
      if ((step_cnt == bus.hold_val) && (bus.hold_cycles != '0) && hold_en_dir) begin
        state_d    = ST_HOLD;
        hold_ctr_d = bus.hold_cycles;
        ret_dir_d  = step_up;
      end else begin
        state_d = step_up ? ST_UP : ST_DN;
      end
    end
  end

  // output decode
  always_comb begin
    bus.cnt     = cnt_q;
    bus.turn    = turn_q;
    bus.holding = (state_q == ST_HOLD);
    bus.dir     = (state_q == ST_HOLD) ? ret_dir_q : (state_q == ST_UP);
  end

endmodule

// File: tb/tb_bounce_counter_hold.sv
module tb_bounce_counter_hold;
  localparam int W   = 3;
  localparam int HC  = 2;
  localparam int MOD = 1 << W;

  logic clk;
  logic rst;

  bounce_counter_hold_if #(.WIDTH(W), .HCW(HC)) bus ();

  bounce_counter_hold #(.WIDTH(W), .HCW(HC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // reference model: integer counter, moving direction and remaining dwell cycles
  int m_cnt     = 0;
  bit m_up      = 1'b1;
  bit m_holding = 1'b0;
  int m_left    = 0;
  bit m_turn    = 1'b0;

  int seq_dflt [17] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
  int seq_wu   [6]  = '{2, 3, 4, 5, 2, 3};
  int seq_wd   [5]  = '{5, 4, 3, 2, 5};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int lo_i, hi_i;
    lo_i = int'(bus.lo);
    hi_i = int'(bus.hi);
    if (!rst) begin
      m_cnt = 0; m_up = 1'b1; m_holding = 1'b0; m_left = 0; m_turn = 1'b0;
    end else if (bus.load) begin
      m_cnt = int'(bus.load_val); m_up = (bus.mode != 2'b10);
      m_holding = 1'b0; m_left = 0; m_turn = 1'b0;
    end else if (!bus.en) begin
      m_turn = 1'b0;
    end else if (lo_i >= hi_i) begin
      m_cnt = lo_i; m_up = 1'b1; m_holding = 1'b0; m_left = 0; m_turn = 1'b0;
    end else if (m_holding) begin
      m_turn = 1'b0;
      m_left = m_left - 1;
      if (m_left <= 0) m_holding = 1'b0;
    end else begin
      m_turn = 1'b0;
      case (bus.mode)
        2'b01: begin
          m_up = 1'b1;
          if (m_cnt >= hi_i) begin m_cnt = lo_i; m_turn = 1'b1; end
          else m_cnt = (m_cnt + 1) % MOD;
        end
        2'b10: begin
          m_up = 1'b0;
          if (m_cnt <= lo_i) begin m_cnt = hi_i; m_turn = 1'b1; end
          else m_cnt = (m_cnt - 1 + MOD) % MOD;
        end
        default: begin
          if (m_up) begin
            if (m_cnt >= hi_i) begin m_cnt = m_cnt - 1; m_up = 1'b0; m_turn = 1'b1; end
            else m_cnt = (m_cnt + 1) % MOD;
          end else begin
            if (m_cnt <= lo_i) begin m_cnt = m_cnt + 1; m_up = 1'b1; m_turn = 1'b1; end
            else m_cnt = (m_cnt - 1 + MOD) % MOD;
          end
        end
      endcase
      if (m_cnt == int'(bus.hold_val) && bus.hold_cycles != 0 &&
          (m_up ? bus.hold_up_en : bus.hold_dn_en)) begin
        m_holding = 1'b1;
        m_left    = int'(bus.hold_cycles);
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".cnt"},     32'(bus.cnt),     32'(m_cnt));
    chk({tag, ".dir"},     32'(bus.dir),     32'(m_up));
    chk({tag, ".holding"}, 32'(bus.holding), 32'(m_holding));
    chk({tag, ".turn"},    32'(bus.turn),    32'(m_turn));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_model(tag);
  endtask

  task automatic defaults();
    bus.en = 1'b1; bus.mode = 2'b00; bus.lo = 3'd0; bus.hi = 3'd7;
    bus.hold_val = 3'd4; bus.hold_cycles = 2'd1; bus.hold_up_en = 1'b1; bus.hold_dn_en = 1'b0;
    bus.load = 1'b0; bus.load_val = 3'd0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cycle("reset");
    rst = 1'b1;
  endtask

  initial begin
    int hold_seen;
    int fours;
    int saved;
    int k;
    rst = 1'b0;
    defaults();

    // 1: default sequence from reset
    @(posedge clk);
    model_step();
    #1;
    chk("reset.cnt", 32'(bus.cnt), 0);
    chk("reset.dir", 32'(bus.dir), 1);
    chk("reset.holding", 32'(bus.holding), 0);
    chk("reset.turn", 32'(bus.turn), 0);
    rst = 1'b1;
    hold_seen = 0;
    for (int i = 1; i < 17; i++) begin
      cycle("dflt");
      chk("dflt.seq", 32'(bus.cnt), 32'(seq_dflt[i]));
      chk("dflt.turnpos", 32'(bus.turn), 32'((i == 9) || (i == 16)));
      hold_seen += int'(bus.holding);
    end
    chk("dflt.hold_len", 32'(hold_seen), 1);

    // 2: three-cycle dwell in both directions
    bus.hold_cycles = 2'd3; bus.hold_dn_en = 1'b1;
    do_reset();
    fours = (bus.cnt == 3'd4) ? 1 : 0;
    for (int i = 1; i < 22; i++) begin
      cycle("hold3");
      if (bus.cnt == 3'd4) fours++;
    end
    chk("hold3.fours", 32'(fours), 8);

    // 3: wrap-up then wrap-down
    bus.mode = 2'b01; bus.lo = 3'd2; bus.hi = 3'd5; bus.hold_cycles = 2'd0;
    bus.load = 1'b1; bus.load_val = 3'd2;
    cycle("wu.load");
    bus.load = 1'b0;
    chk("wu.seq", 32'(bus.cnt), 32'(seq_wu[0]));
    for (int i = 1; i < 6; i++) begin
      cycle("wu");
      chk("wu.seq", 32'(bus.cnt), 32'(seq_wu[i]));
      chk("wu.turnpos", 32'(bus.turn), 32'(i == 4));
    end
    bus.mode = 2'b10; bus.load = 1'b1; bus.load_val = 3'd5;
    cycle("wd.load");
    bus.load = 1'b0;
    chk("wd.seq", 32'(bus.cnt), 32'(seq_wd[0]));
    for (int i = 1; i < 5; i++) begin
      cycle("wd");
      chk("wd.seq", 32'(bus.cnt), 32'(seq_wd[i]));
    end

    // 4: load during a hold with en low
    defaults();
    bus.hold_cycles = 2'd3;
    do_reset();
    k = 0;
    while (!m_holding && k < 40) begin cycle("ldh.wait"); k++; end
    chk("ldh.reached", 32'(m_holding), 1);
    bus.load = 1'b1; bus.load_val = 3'd4; bus.en = 1'b0;
    cycle("ldh");
    chk("ldh.cnt", 32'(bus.cnt), 4);
    chk("ldh.holding", 32'(bus.holding), 0);
    bus.load = 1'b0; bus.en = 1'b1;
    cycle("ldh.after");
    chk("ldh.norehold", 32'(bus.holding), 0);
    chk("ldh.next", 32'(bus.cnt), 5);

    // 5: enable dropped for three cycles
    cycle("en.pre");
    saved = m_cnt;
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle("en.off");
      chk("en.frozen", 32'(bus.cnt), 32'(saved));
      chk("en.turn", 32'(bus.turn), 0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) cycle("en.resume");

    // 6: reset during a down count at 5, then a degenerate range
    defaults();
    k = 0;
    while (!(m_cnt == 5 && !m_up && !m_holding) && k < 40) begin cycle("rst.wait"); k++; end
    chk("rst.reached", 32'(m_cnt == 5 && !m_up), 1);
    do_reset();
    chk("rst.cnt", 32'(bus.cnt), 0);
    chk("rst.dir", 32'(bus.dir), 1);
    chk("rst.turn", 32'(bus.turn), 0);
    chk("rst.holding", 32'(bus.holding), 0);
    bus.lo = 3'd3; bus.hi = 3'd3;
    for (int i = 0; i < 4; i++) begin
      cycle("degen");
      chk("degen.cnt", 32'(bus.cnt), 3);
    end

    // 7: randomized stimulus against the model
    defaults();
    for (int i = 0; i < 600; i++) begin
      rst           = ($urandom_range(0, 99) != 0);
      bus.load      = ($urandom_range(0, 24) == 0);
      bus.en        = ($urandom_range(0, 9) != 0);
      bus.load_val  = W'($urandom);
      bus.hold_val  = W'($urandom);
      bus.hold_up_en = 1'($urandom);
      bus.hold_dn_en = 1'($urandom);
      if ($urandom_range(0, 7) == 0) bus.hold_cycles = HC'($urandom);
      if ($urandom_range(0, 29) == 0) begin
        bus.mode = 2'($urandom);
        bus.lo   = W'($urandom);
        bus.hi   = W'($urandom);
      end
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
